ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set LEDs, 0xFF reset, 0xF4 enable.
- It is the opposite direction to the existing keyboard receiver and shares the same PS2C/PS2D pins through open-drain enables.
- It sits beside the keyboard block under the top level and is driven by game logic, such as mirroring game state onto keyboard LEDs.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles ps2c is held low before the request-to-send (100 us at 100 MHz).
- FILTER_LEN, 8: consecutive equal synchronized samples needed to accept a new ps2c/ps2d level.
- TIMEOUT_CYCLES, 200000: maximum clk cycles between device clock falling edges (2 ms); used only with the optional feature.

Ports:
- clk  in  1  system clock (100 MHz).
- clr  in  1  reset, asynchronous, active-high.
- tx_data  in  8  command byte, sampled on the cycle tx_start is accepted.
- tx_start  in  1  one-cycle request; accepted only when busy=0.
- ps2c_in  in  1  raw PS2C pin level.
- ps2d_in  in  1  raw PS2D pin level.
- ps2c_oe  out  1  1 = drive PS2C low; 0 = release (pulled up).
- ps2d_oe  out  1  1 = drive PS2D low; 0 = release.
- busy  out  1  high from accept until return to IDLE; the receiver ignores frames while busy=1.
- tx_done  out  1  one-cycle pulse when the device ACK is received.
- tx_err  out  1  one-cycle pulse on missing ACK (or timeout); never in the same cycle as tx_done.

Behaviour:
- Reset: the async clr forces state IDLE. All outputs are 0, so both lines are released immediately. Counters and the shift register clear. Reset mid-frame aborts with no done/err pulse.
- Input conditioning:
  - 2-FF synchronizer on each pin, then the FILTER_LEN stability filter.
  - The filter's reset value is 1.
  - fall_c = one-cycle strobe when filtered ps2c goes 1->0.
- Accept: in IDLE with tx_start=1:
  - Latch frame = {stop=1, parity=~^tx_data, tx_data}, LSB first.
  - busy=1 next cycle; enter INHIBIT.
- States and transitions:
  - INHIBIT: ps2c_oe=1, ps2d_oe=0. Stays exactly INHIBIT_CYCLES cycles, then goes to RTS.
  - RTS: ps2d_oe=1 (start bit 0) and ps2c_oe=1 for one cycle, then ps2c_oe=0, then go to SHIFT with bit count 0.
  - SHIFT: on each fall_c, bit count increments. After fall n (n=1..9), ps2d_oe = ~frame[n-1]: 8 data bits, then parity. After fall 10, ps2d_oe=0 (stop, line released). Go to ACK.
  - ACK: on fall 11, sample filtered ps2d. If 0, set the ack flag; if 1, clear it. Go to WAIT_REL.
  - WAIT_REL: wait until filtered ps2c=1 and ps2d=1. Then go to IDLE. Pulse tx_done (ack=1) or tx_err (ack=0) in that same cycle; busy falls in that same cycle.
- ps2d_oe changes only in the cycle after fall_c, never on a rising edge.
- ps2c_oe=0 in all states except INHIBIT and the first RTS cycle.
- tx_start while busy=1 is ignored; no queueing.
- Simultaneous tx_start and a frame ending in the same cycle: the start is ignored because busy is still 1.
- Parity is odd over the 8 data bits: 0xED -> 1, 0xF4 -> 0, 0xFF -> 1.

Optional Feature:
- Macro: PS2_TX_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears on RTS entry and on every fall_c.
  - If it reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_REL, the block releases both lines, pulses tx_err, and goes to IDLE next cycle.
- Undefined: no counter; the block waits indefinitely for device clocks, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package ps2_pkg holds:
  - State enum {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_REL}.
  - Command constants: PS2_CMD_SET_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_ACK=8'hFA.
  - Frame length constant 11.
- Sub-module ps2_line_cond: synchronizer, filter and falling-edge strobe. Instantiated twice (ps2c, ps2d) and reusable by the keyboard receiver.

Test Plan (INHIBIT_CYCLES=20, FILTER_LEN=2, TIMEOUT_CYCLES=500, device BFM with 40-cycle half period):
- Send 0xED with BFM ACK:
  - ps2c_oe high exactly 20 cycles, then ps2d_oe=1.
  - BFM reads bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; busy drops in the same cycle.
- Send 0xF4, BFM withholds ACK (ps2d high at fall 11) -> tx_err pulse, no tx_done, both oe=0.
- tx_start with 0x00 asserted during an 0xFF transfer -> BFM receives only 0xFF (parity 1); one done pulse total.
- clr asserted after fall 5 of 0xED -> ps2c_oe=ps2d_oe=0 combinationally; no pulses. The next send of 0xF4 completes normally.
- Glitch: 1-cycle low pulse on ps2c_in during SHIFT -> bit count unchanged; frame still correct.
- With PS2_TX_TIMEOUT_EN defined: BFM stops clocking after fall 4 -> tx_err 500 cycles after the last fall; state IDLE. Without the macro: busy stays 1.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_pkg
// Purpose : Shared state type and constants for the PS/2 host transmitter.
// Rev     : 1.0  initial release
// ============================================================================
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INHIBIT  = 3'd1,
      RTS      = 3'd2,
      SHIFT    = 3'd3,
      ACK      = 3'd4,
      WAIT_REL = 3'd5
   } ps2_tx_state_e;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_ACK         = 8'hFA;

   // start + 8 data + parity + stop
   localparam int PS2_FRAME_LEN = 11;

   function automatic logic ps2_odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_cond.sv
`default_nettype none
// ============================================================================
// Module  : ps2_line_cond
// Purpose : PS/2 pin conditioning: 2-FF synchronizer, stability filter and
//           falling-edge strobe of the filtered level.
// Rev     : 1.0  initial release
// ============================================================================
module ps2_line_cond #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic clr,
   input  logic pin_i,
   output logic level_o,
   output logic fall_o
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          fall_q;

   // A new level is taken only after FILTER_LEN consecutive samples disagree
   // with the current one; any agreeing sample restarts the run.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pin_i};
         fall_q <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
            fall_q  <= level_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level_o = level_q;
   assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Purpose : PS/2 host-to-device command transmitter (open-drain enables).
//           Optional device-clock watchdog: define PS2_TX_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int IW       = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int FRAME_W  = PS2_FRAME_LEN - 1;
   localparam int LAST_BIT = PS2_FRAME_LEN - 2;

   if (INHIBIT_CYCLES < 1 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("ps2_host_tx: INHIBIT_CYCLES, FILTER_LEN and TIMEOUT_CYCLES must be >= 1");
   end

   ps2_tx_state_e        state_q;
   logic [IW-1:0]        inh_q;
   logic [3:0]           bit_q;
   logic [FRAME_W-1:0]   frame_q;
   logic                 ack_q;
   logic                 c_oe_q;
   logic                 d_oe_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;

   logic w_c_level;
   logic w_c_fall;
   logic w_d_level;
   logic w_d_fall_unused;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WW-1:0] wdog_q;
`endif

   ps2_line_cond #(.FILTER_LEN(FILTER_LEN)) u_cond_c (
      .clk     (clk),
      .clr     (clr),
      .pin_i   (ps2c_in),
      .level_o (w_c_level),
      .fall_o  (w_c_fall)
   );

   ps2_line_cond #(.FILTER_LEN(FILTER_LEN)) u_cond_d (
      .clk     (clk),
      .clr     (clr),
      .pin_i   (ps2d_in),
      .level_o (w_d_level),
      .fall_o  (w_d_fall_unused)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         inh_q   <= '0;
         bit_q   <= '0;
         frame_q <= '0;
         ack_q   <= 1'b0;
         c_oe_q  <= 1'b0;
         d_oe_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wdog_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tx_start) begin
                  frame_q <= {1'b1, ps2_odd_parity(tx_data), tx_data};
                  inh_q   <= '0;
                  busy_q  <= 1'b1;
                  c_oe_q  <= 1'b1;
                  state_q <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                  d_oe_q  <= 1'b1;
                  state_q <= RTS;
               end else begin
                  inh_q <= inh_q + 1'b1;
               end
            end
            RTS: begin
               c_oe_q  <= 1'b0;
               bit_q   <= '0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               // Data moves only while the device holds the clock low; the
               // stop bit (frame MSB = 1) releases the line on fall 10.
               if (w_c_fall) begin
                  d_oe_q <= ~frame_q[bit_q];
                  bit_q  <= bit_q + 1'b1;
                  if (bit_q == 4'(LAST_BIT)) begin
                     state_q <= ACK;
                  end
               end
            end
            ACK: begin
               if (w_c_fall) begin
                  ack_q   <= ~w_d_level;
                  state_q <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (w_c_level && w_d_level) begin
                  busy_q  <= 1'b0;
                  done_q  <= ack_q;
                  err_q   <= ~ack_q;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

`ifdef PS2_TX_TIMEOUT_EN
         // The abort overrides a completion landing in the same cycle, so
         // done and err stay mutually exclusive.
         if (w_c_fall || state_q == RTS) begin
            wdog_q <= '0;
         end else if (state_q inside {SHIFT, ACK, WAIT_REL}) begin
            if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
               c_oe_q  <= 1'b0;
               d_oe_q  <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               err_q   <= 1'b1;
               state_q <= IDLE;
            end else begin
               wdog_q <= wdog_q + 1'b1;
            end
         end
`endif
      end
   end

   assign ps2c_oe = c_oe_q;
   assign ps2d_oe = d_oe_q;
   assign busy    = busy_q;
   assign tx_done = done_q;
   assign tx_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_host_tx
// Purpose : Self-checking bench for ps2_host_tx with a PS/2 device model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int FLT  = 2;
   localparam int TOUT = 500;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_start = 1'b0;
   logic       ps2c_in, ps2d_in;
   logic       ps2c_oe, ps2d_oe, busy, tx_done, tx_err;

   logic dev_c = 1'b1;
   logic dev_d = 1'b1;
   logic glitch = 1'b0;

   assign ps2c_in = ~ps2c_oe & dev_c & ~glitch;
   assign ps2d_in = ~ps2d_oe & dev_d;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .FILTER_LEN     (FLT),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .ps2c_in  (ps2c_in),
      .ps2d_in  (ps2d_in),
      .ps2c_oe  (ps2c_oe),
      .ps2d_oe  (ps2d_oe),
      .busy     (busy),
      .tx_done  (tx_done),
      .tx_err   (tx_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int n_done = 0;
   int n_errp = 0;
   int n_acc = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected bit sequence on the wire, LSB first: data, odd parity, stop.
   function automatic logic [9:0] frame_model(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Per-cycle rule checks
   logic prev_busy = 1'b0, prev_c_oe = 1'b0, prev_d_oe = 1'b0, prev_clr = 1'b1, prev_acc = 1'b0;
   always @(negedge clk) begin
      if (chk_en && !clr && !prev_clr) begin
         check("done_err_exclusive", 32'(tx_done & tx_err), 0);
         if (tx_done || tx_err) check("pulse_with_busy_fall", {prev_busy, busy}, 32'b10);
         if (!busy) check("idle_lines_released", {ps2c_oe, ps2d_oe}, 0);
         if (prev_acc) check("busy_after_accept", 32'(busy), 1);
         if (!prev_c_oe && !ps2c_oe && !tx_err && (ps2d_oe != prev_d_oe))
            check("d_change_on_low_clock", 32'(dev_c), 0);
         if (busy && !prev_busy) n_acc++;
      end
      if (tx_done) n_done++;
      if (tx_err)  n_errp++;
      prev_acc  = tx_start && !busy && !clr;
      prev_busy = busy;
      prev_c_oe = ps2c_oe;
      prev_d_oe = ps2d_oe;
      prev_clr  = clr;
   end

   // Start one transfer and play the device side of it.
   task automatic xfer(input logic [7:0] d, input bit ack, input int abort_k, input int stall_k,
                       input int glitch_k, input bit dup, output logic [9:0] got,
                       output int inh_len, output int rts_len, output int t_fall);
      int guard;
      got = '0; inh_len = 0; rts_len = 0; t_fall = 0;
      tx_data = d; tx_start = 1'b1;
      step();
      tx_start = 1'b0;
      guard = 0;
      while (!(ps2c_oe && ps2d_oe) && guard < 200) begin
         if (ps2c_oe) inh_len++;
         step(); guard++;
      end
      while (ps2c_oe && guard < 200) begin
         rts_len++;
         step(); guard++;
      end
      check("handshake_bound", 32'(guard < 200), 1);
      repeat (HALF) step();
      for (int k = 1; k <= 11; k++) begin
         dev_c = 1'b0;
         t_fall = cyc;
         for (int i = 0; i < HALF; i++) begin
            step();
            if (k == abort_k && i == 20) begin
               clr = 1'b1;
               #1;
               check("abort_lines_released", {ps2c_oe, ps2d_oe}, 0);
               step();
               clr = 1'b0;
               dev_c = 1'b1;
               return;
            end
         end
         dev_c = 1'b1;
         if (k <= 10) got[k-1] = ps2d_in;
         if (k == stall_k) return;
         for (int i = 0; i < HALF; i++) begin
            if (i == 20) begin
               if (k == glitch_k) glitch = 1'b1;
               if (k == 10 && ack) dev_d = 1'b0;
               if (k == 3 && dup) begin tx_data = 8'h00; tx_start = 1'b1; end
            end
            step();
            glitch = 1'b0;
            tx_start = 1'b0;
         end
      end
      dev_d = 1'b1;
      guard = 0;
      while (busy && guard < 300) begin step(); guard++; end
      check("end_idle", 32'(busy), 0);
   endtask

   initial begin
      #2_000_000;
      n_err++;
      $display("FAIL global_time_limit: got cycle %0d expected completion", cyc);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      logic [9:0] got, m;
      int inh, rts, tf, d0, e0, a0, guard, dly;

      repeat (3) step();
      check("reset_outputs", {ps2c_oe, ps2d_oe, busy, tx_done, tx_err}, 0);
      clr = 1'b0;
      repeat (5) step();
      chk_en = 1'b1;

      m = frame_model(8'hED); check("model_ED", m, 10'h3ED);
      m = frame_model(8'hF4); check("model_F4", m, 10'h2F4);
      m = frame_model(8'hFF); check("model_FF", m, 10'h3FF);

      // 0xED with ACK
      d0 = n_done; e0 = n_errp;
      xfer(8'hED, 1'b1, 0, 0, 0, 1'b0, got, inh, rts, tf);
      check("ED_inhibit_len", inh, INH);
      check("ED_rts_len", rts, 1);
      check("ED_bits_literal", got, 10'h3ED);
      check("ED_done_count", n_done - d0, 1);
      check("ED_err_count", n_errp - e0, 0);
      repeat (10) step();

      // 0xF4 without ACK
      d0 = n_done; e0 = n_errp;
      xfer(8'hF4, 1'b0, 0, 0, 0, 1'b0, got, inh, rts, tf);
      check("F4_bits", got, frame_model(8'hF4));
      check("F4_noack_err", n_errp - e0, 1);
      check("F4_noack_done", n_done - d0, 0);
      check("F4_lines", {ps2c_oe, ps2d_oe}, 0);
      repeat (10) step();

      // 0xFF with a competing start mid-transfer
      d0 = n_done; a0 = n_acc;
      xfer(8'hFF, 1'b1, 0, 0, 0, 1'b1, got, inh, rts, tf);
      repeat (100) step();
      check("FF_bits", got, 10'h3FF);
      check("FF_done_count", n_done - d0, 1);
      check("FF_single_accept", n_acc - a0, 1);
      check("FF_idle_after", {busy, ps2c_oe}, 0);

      // Reset after fall 5 of 0xED, then 0xF4 normally
      d0 = n_done; e0 = n_errp;
      xfer(8'hED, 1'b1, 5, 0, 0, 1'b0, got, inh, rts, tf);
      repeat (20) step();
      check("abort_no_pulses", (n_done - d0) + (n_errp - e0), 0);
      check("abort_busy", 32'(busy), 0);
      xfer(8'hF4, 1'b1, 0, 0, 0, 1'b0, got, inh, rts, tf);
      check("post_abort_bits", got, frame_model(8'hF4));
      check("post_abort_done", n_done - d0, 1);
      repeat (10) step();

      // Glitch on ps2c during SHIFT
      d0 = n_done;
      xfer(8'hA5, 1'b1, 0, 0, 3, 1'b0, got, inh, rts, tf);
      check("glitch_bits", got, frame_model(8'hA5));
      check("glitch_done", n_done - d0, 1);
      repeat (10) step();

      // Device stops clocking after fall 4
      e0 = n_errp;
      xfer(8'hED, 1'b1, 0, 4, 0, 1'b0, got, inh, rts, tf);
`ifdef PS2_TX_TIMEOUT_EN
      guard = 0;
      while (n_errp == e0 && guard < 2000) begin step(); guard++; end
      dly = cyc - tf;
      check("timeout_err", n_errp - e0, 1);
      check("timeout_delay_window", 32'(dly >= TOUT && dly <= TOUT + 20), 1);
      check("timeout_idle", {busy, ps2c_oe, ps2d_oe}, 0);
`else
      dly = 0;
      guard = 0;
      repeat (3 * TOUT) step();
      check("stall_busy_held", 32'(busy), 1);
      check("stall_no_err", n_errp - e0 + dly + guard, 0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      check("stall_reset_idle", {busy, ps2c_oe, ps2d_oe}, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
